frogger_qsys_hpi_pio: RTL

Parametrised Avalon-MM parallel I/O slave, the next generation of the 16-bit OTG HPI data/address/control PIOs in the Frogger Qsys system. Adds per-bit direction control, atomic set/clear of output bits, a configurable input synchroniser, edge capture and a maskable level interrupt to the CPU. One instance per HPI signal group, sitting between the Nios II data master and the CY7C67200 HPI pins.

---
 rtl/frogger_qsys_hpi_pio.sv | 122 ++++++++++++
 1 files changed

// File: rtl/frogger_qsys_hpi_pio.sv
// Avalon-MM PIO slave: per-bit direction, set/clear, synchronised inputs, edge capture, masked irq.
// Reads have 1-cycle latency and writes land at the sampling edge; there is no backpressure (no waitrequest).
module frogger_qsys_hpi_pio #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] port_oe,
  output logic                  irq
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] PRIME_DONE    = 3'(SYNC_STAGES + 1);

  word_t data_q, data_d;
  word_t dir_q, dir_d;
  word_t mask_q, mask_d;
  word_t cap_q, cap_d;
  word_t prev_q;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
  logic [2:0]  prime_q, prime_d;
  logic [31:0] rd_q, rd_d;

  word_t in_sync, edge_raw, edge_det, wdata, clr;
  logic  wr_en, armed;

  // Only the low DATA_WIDTH bits of writedata matter; this net absorbs the rest.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wdata   = writedata[DATA_WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign armed   = (prime_q == PRIME_DONE);

  always_comb begin
    edge_raw = in_sync ^ prev_q;
    if (EDGE_TYPE == 0) begin
      edge_raw = in_sync & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = ~in_sync & prev_q;
    end
  end

  // Until the chain has flushed post-reset levels, any apparent edge is an artefact of the zeroed flops.
  assign edge_det = armed ? edge_raw : '0;

  always_comb begin
    data_d  = data_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    clr     = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d = wdata;
        ADDR_DIR:      dir_d  = wdata;
        ADDR_MASK:     mask_d = wdata;
        ADDR_EDGE:     clr    = wdata;
        ADDR_OUTSET:   data_d = data_q | wdata;
        ADDR_OUTCLEAR: data_d = data_q & ~wdata;
        default:       ;
      endcase
    end
    // A fresh edge overrides a same-cycle clear so no event is lost.
    cap_d   = (cap_q & ~clr) | edge_det;
    prime_d = armed ? prime_q : prime_q + 3'd1;

    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[DATA_WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
      ADDR_DIR:  rd_d[DATA_WIDTH-1:0] = dir_q;
      ADDR_MASK: rd_d[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[DATA_WIDTH-1:0] = cap_q;
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[DATA_WIDTH-1:0];
      dir_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      prime_q <= '0;
      rd_q    <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      prev_q  <= in_sync;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prime_q <= prime_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = data_q;
  assign port_oe  = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule
